// File: rtl/div24_seq_pkg.sv
// ============================================================================
// Module : div24_seq_pkg
// Brief  : Shared mantissa width, divider state encoding and sizing helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package div24_seq_pkg;

  localparam int MANT_W = 24;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic int cnt_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div24_seq_if.sv
// ============================================================================
// Module : div24_seq_if
// Brief  : Start/done handshake and operand/result bundle for div24_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface div24_seq_if #(
  parameter int WIDTH = div24_seq_pkg::MANT_W
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  modport master (output start, A, B, input  ready, done, Q, R, div_by_zero);
  modport slave  (input  start, A, B, output ready, done, Q, R, div_by_zero);
endinterface

`default_nettype wire

// File: rtl/div24_seq_sub25.sv
// ============================================================================
// Module : div24_seq_sub25
// Brief  : (WIDTH+1)-bit ripple subtractor D = A - B with borrow out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div24_seq_sub25 #(
  parameter int W = 25
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] D,
  output logic         Bout
);
  logic [W:0] w_bw;

  assign w_bw[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign D[i]      = A[i] ^ B[i] ^ w_bw[i];
    assign w_bw[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & w_bw[i]);
  end

  assign Bout = w_bw[W];
endmodule

`default_nettype wire

// File: rtl/div24_seq.sv
// ============================================================================
// Module : div24_seq
// Brief  : Sequential radix-2 restoring unsigned divider, one quotient bit/clk.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div24_seq
  import div24_seq_pkg::*;
#(
  parameter int WIDTH = MANT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  div24_seq_if.slave   bus
);
  localparam int             CW     = cnt_w(WIDTH);
  localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

  div_state_e       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_next_rem;
  logic [WIDTH-1:0] w_next_quo;
  logic             w_borrow;
  logic             w_accept;
  logic             w_unused_rem_msb;

  // Only the low WIDTH bits of rem feed the next shift; rem < dvs keeps the MSB clear.
  assign w_shift          = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_unused_rem_msb = r_rem[WIDTH];

  div24_seq_sub25 #(.W(WIDTH + 1)) u_sub (
    .A    (w_shift),
    .B    ({1'b0, r_dvs}),
    .D    (w_trial),
    .Bout (w_borrow)
  );

  assign w_next_rem = w_borrow ? w_shift : w_trial;
  assign w_next_quo = {r_quo[WIDTH-2:0], ~w_borrow};

  assign bus.ready       = (r_state == DIV_IDLE) || (r_state == DIV_DONE);
  assign w_accept        = bus.start & bus.ready;
  assign bus.done        = r_done;
  assign bus.Q           = r_q;
  assign bus.R           = r_r;
  assign bus.div_by_zero = r_dbz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DIV_IDLE;
      r_count <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE, DIV_DONE: begin
          if (w_accept) begin
            r_state <= DIV_BUSY;
            r_rem   <= '0;
            r_quo   <= bus.A;
            r_dvs   <= bus.B;
            r_count <= '0;
            r_dbz   <= (bus.B == '0);
            r_done  <= 1'b0;
          end
        end
        DIV_BUSY: begin
          r_rem   <= w_next_rem;
          r_quo   <= w_next_quo;
          r_count <= r_count + 1'b1;
          if (r_count == c_last) begin
            r_state <= DIV_DONE;
            r_q     <= w_next_quo;
            r_r     <= w_next_rem[WIDTH-1:0];
            r_done  <= 1'b1;
          end
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_div24_seq.sv
// ============================================================================
// Module : tb_div24_seq
// Brief  : Self-checking bench for div24_seq against a cycle-level reference.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div24_seq;
  localparam int         W    = 24;
  localparam logic [W-1:0] ONES = '1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div24_seq_if #(.WIDTH(W)) bus ();
  div24_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a result appears W edges after acceptance, computed with / and %.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic         m_dbz  = 1'b0;
  logic [W-1:0] m_q    = '0;
  logic [W-1:0] m_r    = '0;
  logic [W-1:0] m_pq   = '0;
  logic [W-1:0] m_pr   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_dbz = 1'b0; m_q = '0; m_r = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_q = m_pq; m_r = m_pr;
      end
    end else if (bus.start) begin
      m_left = W;
      m_done = 1'b0;
      m_dbz  = (bus.B == '0);
      if (bus.B == '0) begin
        m_pq = ONES; m_pr = bus.A;
      end else begin
        m_pq = bus.A / bus.B; m_pr = bus.A % bus.B;
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", {31'd0, bus.ready}, {31'd0, (m_left == 0)});
    chk("done",  {31'd0, bus.done},  {31'd0, m_done});
    chk("Q",     {8'd0, bus.Q},      {8'd0, m_q});
    chk("R",     {8'd0, bus.R},      {8'd0, m_r});
    chk("dbz",   {31'd0, bus.div_by_zero}, {31'd0, m_dbz});
  end

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = s; bus.A = a; bus.B = b;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); lat++; #1;
      if (bus.done) break;
    end
    if (!bus.done) chk("done_timeout", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    int lat;
    @(negedge clk); drive(1'b1, a, b);
    @(posedge clk);
    @(negedge clk); drive(1'b0, W'($urandom), W'($urandom));
    wait_done(lat);
    chk({tag, "_lat"}, lat, 32'd24);
    chk({tag, "_Q"}, {8'd0, bus.Q}, {8'd0, eq});
    chk({tag, "_R"}, {8'd0, bus.R}, {8'd0, er});
    chk({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, edbz});
  endtask

  initial begin
    int lat;
    logic [W-1:0] a, b;
    drive(1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_done",  {31'd0, bus.done}, 32'd0);
    chk("rst_Q",     {8'd0, bus.Q}, 32'd0);
    chk("rst_R",     {8'd0, bus.R}, 32'd0);
    chk("rst_dbz",   {31'd0, bus.div_by_zero}, 32'd0);
    rst_n = 1'b1;

    run_op("100_7",   24'd100,     24'd7,  24'd14,       24'd2,       1'b0);
    run_op("max_1",   24'hFFFFFF,  24'd1,  24'hFFFFFF,   24'd0,       1'b0);
    run_op("5_9",     24'd5,       24'd9,  24'd0,        24'd5,       1'b0);
    run_op("77_77",   24'd77,      24'd77, 24'd1,        24'd0,       1'b0);
    run_op("div0",    24'h123456,  24'd0,  24'hFFFFFF,   24'h123456,  1'b1);

    // start pulsed at busy step 5 must be ignored
    @(negedge clk); drive(1'b1, 24'd1000, 24'd7);
    @(posedge clk);
    @(negedge clk); drive(1'b0, '0, '0);
    repeat (4) @(negedge clk);
    drive(1'b1, 24'd50, 24'd5);
    @(negedge clk); drive(1'b0, '0, '0);
    wait_done(lat);
    chk("ign_lat", lat, 32'd19);
    chk("ign_Q", {8'd0, bus.Q}, 32'd142);
    chk("ign_R", {8'd0, bus.R}, 32'd6);

    // start held high across DONE: one-cycle done pulse per result
    @(negedge clk); drive(1'b1, 24'd81, 24'd9);
    @(posedge clk); #1;
    chk("hold_drop", {31'd0, bus.done}, 32'd0);
    wait_done(lat);
    chk("hold_lat", lat, 32'd24);
    chk("hold_Q", {8'd0, bus.Q}, 32'd9);
    chk("hold_R", {8'd0, bus.R}, 32'd0);
    @(posedge clk); #1;
    chk("hold_pulse1", {31'd0, bus.done}, 32'd0);
    chk("hold_busy", {31'd0, bus.ready}, 32'd0);
    @(negedge clk); drive(1'b0, '0, '0);
    wait_done(lat);
    chk("hold2_lat", lat, 32'd24);

    // asynchronous reset in the middle of an operation
    @(negedge clk); drive(1'b1, 24'd12345, 24'd11);
    @(posedge clk);
    @(negedge clk); drive(1'b0, '0, '0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, bus.ready}, 32'd1);
    chk("arst_done",  {31'd0, bus.done}, 32'd0);
    chk("arst_Q",     {8'd0, bus.Q}, 32'd0);
    chk("arst_R",     {8'd0, bus.R}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst", 24'd5000, 24'd3, 24'd1666, 24'd2, 1'b0);

    repeat (2000) begin
      a = W'($urandom);
      b = W'($urandom >> $urandom_range(8, 31));
      if (b == '0) run_op("rnd", a, b, ONES, a, 1'b1);
      else         run_op("rnd", a, b, a / b, a % b, 1'b0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
